cnn_load_ctrl: RTL and testbench

Parametrised load sequencer that fills the CNN's on-chip image buffer and filter buffer from external memory before a convolution pass. It splits the image into bursts of at most `BLOCK_SIZE` words, then fetches `NUM_FILTERS` filters one burst each. Filter writes honour backpressure from the filter buffer. It sits between the top-level CNN controller, the DMA/memory port and the two buffers, and reports `done` when both buffers are loaded.

---
 rtl/cnn_load_ctrl_if.sv | 46 ++++
 rtl/cnn_load_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cnn_load_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_load_ctrl_if.sv
// rtl/cnn_load_ctrl_if.sv - Control, memory-port and buffer-write bundle of cnn_load_ctrl
interface cnn_load_ctrl_if #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_SIZE  = 150,
    parameter int IMG_WORDS   = 1024,
    parameter int NUM_FILTERS = 6
);
    localparam int LW = $clog2(BLOCK_SIZE + 1);
    localparam int IW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    logic                  start;
    logic [ADDR_WIDTH-1:0] img_base;
    logic [ADDR_WIDTH-1:0] flt_base;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LW-1:0]         mem_len;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rready;
    logic                  img_wr_en;
    logic [IW-1:0]         img_wr_addr;
    logic [DATA_WIDTH-1:0] img_wr_data;
    logic                  flt_wr_en;
    logic [DATA_WIDTH-1:0] flt_wr_data;
    logic [FW-1:0]         flt_sel;
    logic                  flt_last;
    logic                  flt_full;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        input  start, img_base, flt_base, mem_ack, mem_rvalid, mem_rdata, flt_full,
        output mem_req, mem_addr, mem_len, mem_rready, img_wr_en, img_wr_addr, img_wr_data,
               flt_wr_en, flt_wr_data, flt_sel, flt_last, busy, done, checksum
    );

    modport slave (
        output start, img_base, flt_base, mem_ack, mem_rvalid, mem_rdata, flt_full,
        input  mem_req, mem_addr, mem_len, mem_rready, img_wr_en, img_wr_addr, img_wr_data,
               flt_wr_en, flt_wr_data, flt_sel, flt_last, busy, done, checksum
    );
endinterface

// File: rtl/cnn_load_ctrl.sv
// rtl/cnn_load_ctrl.sv - CNN image/filter buffer load sequencer (optional running checksum: CNN_LOAD_CHECKSUM_EN)
module cnn_load_ctrl #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int BLOCK_SIZE   = 150,
    parameter int IMG_WORDS    = 1024,
    parameter int FILTER_WORDS = 25,
    parameter int NUM_FILTERS  = 6
) (
    input logic             clk,
    input logic             reset,
    cnn_load_ctrl_if.master bus
);
    localparam int LW = $clog2(BLOCK_SIZE + 1);
    localparam int IW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    // Counters must be able to hold their terminal value.
    localparam int CW = $clog2(IMG_WORDS + 1);
    localparam int NW = $clog2(NUM_FILTERS + 1);

    localparam logic [CW-1:0]         IMG_TOTAL  = CW'(IMG_WORDS);
    localparam logic [NW-1:0]         FLT_TOTAL  = NW'(NUM_FILTERS);
    localparam logic [LW-1:0]         FIRST_LEN  = LW'((IMG_WORDS > BLOCK_SIZE) ? BLOCK_SIZE : IMG_WORDS);
    localparam logic [LW-1:0]         FLT_LEN    = LW'(FILTER_WORDS);
    localparam logic [ADDR_WIDTH-1:0] FLT_STRIDE = ADDR_WIDTH'(FILTER_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMG_REQ,
        S_IMG_DATA,
        S_FLT_REQ,
        S_FLT_DATA,
        S_FIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] img_base_q;
    logic [ADDR_WIDTH-1:0] flt_base_q;
    logic [CW-1:0]         img_cnt;
    logic [LW-1:0]         beat_cnt;
    logic [NW-1:0]         flt_idx;

    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [LW-1:0]         mem_len_q;
    logic                  img_wr_en_q;
    logic [IW-1:0]         img_wr_addr_q;
    logic [DATA_WIDTH-1:0] img_wr_data_q;
    logic                  flt_wr_en_q;
    logic [DATA_WIDTH-1:0] flt_wr_data_q;
    logic [FW-1:0]         flt_sel_q;
    logic                  flt_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  rready;
    logic                  beat;
    logic                  burst_end;
    logic [CW-1:0]         img_cnt_inc;
    logic [LW-1:0]         beat_cnt_inc;
    logic [NW-1:0]         flt_idx_inc;
    logic [31:0]           img_rem;
    logic [LW-1:0]         img_len_next;

    // rready is combinational so that filter-buffer backpressure stalls the
    // memory in the same cycle it is raised.
    always_comb begin
        rready       = (state == S_IMG_DATA) || ((state == S_FLT_DATA) && !bus.flt_full);
        beat         = bus.mem_rvalid && rready;
        img_cnt_inc  = img_cnt + CW'(1);
        beat_cnt_inc = beat_cnt + LW'(1);
        flt_idx_inc  = flt_idx + NW'(1);
        burst_end    = (beat_cnt_inc == mem_len_q);
        img_rem      = 32'(IMG_TOTAL - img_cnt_inc);
        img_len_next = (img_rem > 32'(BLOCK_SIZE)) ? LW'(BLOCK_SIZE) : LW'(img_rem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            img_base_q    <= '0;
            flt_base_q    <= '0;
            img_cnt       <= '0;
            beat_cnt      <= '0;
            flt_idx       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_len_q     <= '0;
            img_wr_en_q   <= 1'b0;
            img_wr_addr_q <= '0;
            img_wr_data_q <= '0;
            flt_wr_en_q   <= 1'b0;
            flt_wr_data_q <= '0;
            flt_sel_q     <= '0;
            flt_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            img_wr_en_q <= 1'b0;
            flt_wr_en_q <= 1'b0;
            flt_last_q  <= 1'b0;
            done_q      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_IMG_REQ;
                        busy_q     <= 1'b1;
                        img_base_q <= bus.img_base;
                        flt_base_q <= bus.flt_base;
                        img_cnt    <= '0;
                        beat_cnt   <= '0;
                        flt_idx    <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= bus.img_base;
                        mem_len_q  <= FIRST_LEN;
                    end
                end

                S_IMG_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= S_IMG_DATA;
                    end
                end

                S_IMG_DATA: begin
                    if (beat) begin
                        img_wr_en_q   <= 1'b1;
                        img_wr_addr_q <= img_cnt[IW-1:0];
                        img_wr_data_q <= bus.mem_rdata;
                        img_cnt       <= img_cnt_inc;
                        if (burst_end) begin
                            beat_cnt  <= '0;
                            mem_req_q <= 1'b1;
                            if (img_cnt_inc < IMG_TOTAL) begin
                                state      <= S_IMG_REQ;
                                mem_addr_q <= img_base_q + ADDR_WIDTH'(img_cnt_inc);
                                mem_len_q  <= img_len_next;
                            end else begin
                                state      <= S_FLT_REQ;
                                mem_addr_q <= flt_base_q;
                                mem_len_q  <= FLT_LEN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt_inc;
                        end
                    end
                end

                S_FLT_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= S_FLT_DATA;
                    end
                end

                S_FLT_DATA: begin
                    if (beat) begin
                        // flt_sel travels with the write so the last word of a
                        // filter is tagged with its own index, not the next one.
                        flt_wr_en_q   <= 1'b1;
                        flt_wr_data_q <= bus.mem_rdata;
                        flt_sel_q     <= flt_idx[FW-1:0];
                        flt_last_q    <= burst_end;
                        if (burst_end) begin
                            beat_cnt <= '0;
                            flt_idx  <= flt_idx_inc;
                            if (flt_idx_inc < FLT_TOTAL) begin
                                state      <= S_FLT_REQ;
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= mem_addr_q + FLT_STRIDE;
                            end else begin
                                state <= S_FIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt_inc;
                        end
                    end
                end

                // One cycle for the final buffer write to land before done.
                S_FIN: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CNN_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if ((state == S_IDLE) && bus.start) begin
            sum_q <= '0;
        end else if (beat) begin
            sum_q <= sum_q + bus.mem_rdata;
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_len     = mem_len_q;
    assign bus.mem_rready  = rready;
    assign bus.img_wr_en   = img_wr_en_q;
    assign bus.img_wr_addr = img_wr_addr_q;
    assign bus.img_wr_data = img_wr_data_q;
    assign bus.flt_wr_en   = flt_wr_en_q;
    assign bus.flt_wr_data = flt_wr_data_q;
    assign bus.flt_sel     = flt_sel_q;
    assign bus.flt_last    = flt_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_cnn_load_ctrl.sv
// tb/tb_cnn_load_ctrl.sv - Directed self-checking bench for cnn_load_ctrl
module tb_cnn_load_ctrl;
    logic clk;
    logic reset;

    cnn_load_ctrl_if bus ();

    cnn_load_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // observation counters, written by the memory/monitor process
    int img_n, img_bad, flt_n, flt_bad, last_n, done_n, rdy_bad;
    int req_addr_q[$];
    int req_len_q[$];

    // memory model state
    int         pend = 0;
    int         woff = 0;
    int         burst_no = 0;
    int         fidx = 0;
    int         lat_len = 0;
    logic [19:0] lat_addr = '0;
    logic [19:0] img_base_tb = '0;
    logic [19:0] aoff;
    bit         took = 0;
    bit         ack_took = 0;
    bit         cur_img = 1;
    bit         toggle_full = 0;
    bit         flt_one = 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        img_n = 0; img_bad = 0; flt_n = 0; flt_bad = 0; last_n = 0; done_n = 0; rdy_bad = 0;
        req_addr_q.delete();
        req_len_q.delete();
        burst_no = 0;
    endtask

    // Zero-latency memory plus output monitor, all activity on the falling edge.
    initial begin
        int fe, we;
        logic [15:0] edat;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.flt_full = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.img_wr_en === 1'b1) begin
                if (bus.img_wr_addr !== 10'(img_n) || bus.img_wr_data !== 16'(img_n)) img_bad++;
                img_n++;
            end
            if (bus.flt_wr_en === 1'b1) begin
                fe = flt_n / 25;
                we = flt_n % 25;
                edat = flt_one ? 16'd1 : (16'h8000 | 16'(fe << 8) | 16'(we));
                if (bus.flt_sel !== 3'(fe) || bus.flt_wr_data !== edat || bus.flt_last !== (we == 24)) flt_bad++;
                if (bus.flt_last === 1'b1) last_n++;
                flt_n++;
            end else if (bus.flt_last !== 1'b0) begin
                flt_bad++;
            end
            if (bus.done === 1'b1) done_n++;
            if (reset) begin
                pend = 0; took = 0; ack_took = 0;
            end else begin
                if (took) begin pend--; woff++; end
                if (ack_took) begin pend = lat_len; woff = 0; end
                if (bus.mem_rready !== ((pend > 0) ? (cur_img ? 1'b1 : !bus.flt_full) : 1'b0)) rdy_bad++;
            end
            if (toggle_full) bus.flt_full = !bus.flt_full;
            else bus.flt_full = 1'b0;
            bus.mem_ack = bus.mem_req && !reset;
            bus.mem_rvalid = (pend > 0);
            aoff = lat_addr + 20'(woff);
            bus.mem_rdata = cur_img ? 16'(aoff - img_base_tb)
                                    : (flt_one ? 16'd1 : (16'h8000 | 16'(fidx << 8) | 16'(woff)));
            #1;
            took = bus.mem_rvalid && bus.mem_rready;
            ack_took = bus.mem_req && bus.mem_ack;
            if (ack_took) begin
                req_addr_q.push_back(int'(bus.mem_addr));
                req_len_q.push_back(int'(bus.mem_len));
                lat_addr = bus.mem_addr;
                lat_len = int'(bus.mem_len);
                cur_img = (burst_no < 7);
                fidx = burst_no - 7;
                burst_no++;
            end
        end
    end

    task automatic run_load(input logic [19:0] ib, input logic [19:0] fb, input bit start_again, output int lat);
        clear_mon();
        img_base_tb = ib;
        bus.img_base = ib;
        bus.flt_base = fb;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("first_busy", 64'(bus.busy), 64'd1);
        chk("first_req", 64'(bus.mem_req), 64'd1);
        chk("first_addr", 64'(bus.mem_addr), 64'(ib));
        chk("first_len", 64'(bus.mem_len), 64'd150);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 5000) begin
            bus.start = (start_again && (lat == 40 || lat == 1100)) ? 1'b1 : 1'b0;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(bus.done), 64'd1);
        chk("busy_at_done", 64'(bus.busy), 64'd1);
        if (start_again) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("done_after", 64'(bus.done), 64'd0);
        tick();
        chk("idle_req", 64'(bus.mem_req), 64'd0);
    endtask

    task automatic check_run(input logic [19:0] ib, input logic [19:0] fb, input bit chk_data);
        int bad;
        logic [19:0] ea;
        int el;
        chk("img_count", 64'(img_n), 64'd1024);
        chk("img_order", 64'(img_bad), 64'd0);
        chk("flt_count", 64'(flt_n), 64'd150);
        if (chk_data) chk("flt_order", 64'(flt_bad), 64'd0);
        chk("flt_last_count", 64'(last_n), 64'd6);
        chk("done_count", 64'(done_n), 64'd1);
        chk("rready", 64'(rdy_bad), 64'd0);
        chk("req_count", 64'(req_addr_q.size()), 64'd13);
        bad = 0;
        for (int k = 0; k < req_addr_q.size() && k < 13; k++) begin
            ea = (k < 7) ? ib + 20'(150 * k) : fb + 20'(25 * (k - 7));
            el = (k < 6) ? 150 : ((k == 6) ? 124 : 25);
            if (req_addr_q[k] != int'(ea) || req_len_q[k] != el) bad++;
        end
        chk("req_table", 64'(bad), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        logic [15:0] exp_sum;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.img_base = '0;
        bus.flt_base = '0;
        repeat (3) tick();
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_len", 64'(bus.mem_len), 64'd0);
        chk("rst_rready", 64'(bus.mem_rready), 64'd0);
        chk("rst_img_wr_en", 64'(bus.img_wr_en), 64'd0);
        chk("rst_flt_wr_en", 64'(bus.flt_wr_en), 64'd0);
        chk("rst_flt_last", 64'(bus.flt_last), 64'd0);
        chk("rst_flt_sel", 64'(bus.flt_sel), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_checksum", 64'(bus.checksum), 64'd0);
        reset = 1'b0;
        tick();

        // baseline load, image words = index, filter words = 1
        flt_one = 1;
        run_load(20'h00100, 20'h20000, 1'b0, lat);
        chk("latency_a", 64'(lat), 64'd1188);
        check_run(20'h00100, 20'h20000, 1'b1);
        exp_sum = '0;
        for (int i = 0; i < 1024; i++) exp_sum = exp_sum + 16'(i);
        exp_sum = exp_sum + 16'd150;
`ifdef CNN_LOAD_CHECKSUM_EN
        chk("checksum", 64'(bus.checksum), 64'(exp_sum));
`else
        chk("checksum_off", 64'(bus.checksum), 64'd0);
`endif

        // filter backpressure toggling, patterned filter words
        flt_one = 0;
        toggle_full = 1;
        run_load(20'h00100, 20'h0ABCD, 1'b0, lat);
        check_run(20'h00100, 20'h0ABCD, 1'b1);
        toggle_full = 0;
        tick();

        // address wrap on image and filter regions
        run_load(20'hFFFF0, 20'hFFFE0, 1'b0, lat);
        chk("wrap_addr0", 64'(req_addr_q[0]), 64'h0FFFF0);
        chk("wrap_addr1", 64'(req_addr_q[1]), 64'h000086);
        check_run(20'hFFFF0, 20'hFFFE0, 1'b1);

        // reset in the middle of the third image burst (img_cnt = 300)
        clear_mon();
        img_base_tb = 20'h00100;
        bus.img_base = 20'h00100;
        bus.flt_base = 20'h20000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 20'h0022C) && n < 1000) begin
            tick();
            n++;
        end
        chk("mid_req_addr", 64'(bus.mem_addr), 64'h22C);
        tick();
        chk("mid_rready", 64'(bus.mem_rready), 64'd1);
        chk("mid_img_n", 64'(img_n), 64'd300);
        reset = 1'b1;
        tick();
        chk("mrst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("mrst_rready", 64'(bus.mem_rready), 64'd0);
        chk("mrst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("mrst_mem_len", 64'(bus.mem_len), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_img_wr_en", 64'(bus.img_wr_en), 64'd0);
        chk("mrst_img_wr_addr", 64'(bus.img_wr_addr), 64'd0);
        chk("mrst_img_wr_data", 64'(bus.img_wr_data), 64'd0);
        chk("mrst_checksum", 64'(bus.checksum), 64'd0);
        // reset and start together: reset wins
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rst_start_busy", 64'(bus.busy), 64'd0);
        chk("rst_start_req", 64'(bus.mem_req), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_req", 64'(bus.mem_req), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        flt_one = 1;
        run_load(20'h00100, 20'h20000, 1'b0, lat);
        chk("latency_restart", 64'(lat), 64'd1188);
        check_run(20'h00100, 20'h20000, 1'b1);

        // extra start pulses while busy and on the done cycle
        run_load(20'h00100, 20'h20000, 1'b1, lat);
        chk("latency_restart_ignored", 64'(lat), 64'd1188);
        check_run(20'h00100, 20'h20000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
